ram_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-port 1024x16 `RAM` block. It accepts read/write requests from two independent masters through a hold-until-granted handshake and grants bursts of up to `MAX_BURST` beats. It drives the RAM's `RD`/`WR`/`ADDR`/`IN` from registers and routes read data back to the originating requester with a fixed latency. It sits directly in front of the `RAM` instance and is the only driver of its control pins.

---
 rtl/ram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and command sequencer for a single-port
// 1024x16 RAM, with a fixed two-cycle read-response tag pipeline.
module ram_arbiter #(
    parameter int DW        = 16,
    parameter int AW        = 10,
    parameter int MAX_BURST = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          RVALID0,
    output logic          RVALID1,
    output logic [DW-1:0] RDATA0,
    output logic [DW-1:0] RDATA1,
    output logic          RAM_RD,
    output logic          RAM_WR,
    output logic [AW-1:0] RAM_ADDR,
    output logic [DW-1:0] RAM_IN,
    input  logic [DW-1:0] RAM_OUT
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    localparam int BCW = 4;
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(MAX_BURST - 1);

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic           last;
    logic           last_nxt;
    logic [BCW-1:0] beat_cnt;
    logic [BCW-1:0] beat_cnt_nxt;

    logic           acc0;
    logic           acc1;
    logic           accept;
    logic           acc_id;
    logic           acc_we;
    logic [AW-1:0]  acc_addr;
    logic [DW-1:0]  acc_wdata;

    logic           vld_p1;
    logic           id_p1;
    logic           vld_p2;
    logic           id_p2;

    assign GNT0 = (state == GRANT0);
    assign GNT1 = (state == GRANT1);

    assign acc0      = REQ0 && GNT0;
    assign acc1      = REQ1 && GNT1;
    assign accept    = acc0 || acc1;
    assign acc_id    = acc1;
    assign acc_we    = acc1 ? WE1    : WE0;
    assign acc_addr  = acc1 ? ADDR1  : ADDR0;
    assign acc_wdata = acc1 ? WDATA1 : WDATA0;

    // A grant ends on a dropped request (no accept) or on the burst-closing
    // accept; handoff goes straight to the other requester when it waits.
    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                beat_cnt_nxt = '0;
                if (REQ0 && REQ1) begin
                    state_nxt = last ? GRANT0 : GRANT1;
                end else if (REQ0) begin
                    state_nxt = GRANT0;
                end else if (REQ1) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                if (!REQ0 || (beat_cnt == BEAT_LAST)) begin
                    last_nxt     = 1'b0;
                    beat_cnt_nxt = '0;
                    state_nxt    = REQ1 ? GRANT1 : IDLE;
                end else begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
            GRANT1: begin
                if (!REQ1 || (beat_cnt == BEAT_LAST)) begin
                    last_nxt     = 1'b1;
                    beat_cnt_nxt = '0;
                    state_nxt    = REQ0 ? GRANT0 : IDLE;
                end else begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            last     <= 1'b1;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Stage p0 -> RAM command register: address and data hold between accepts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RAM_RD   <= 1'b0;
            RAM_WR   <= 1'b0;
            RAM_ADDR <= '0;
            RAM_IN   <= '0;
        end else if (accept) begin
            RAM_RD   <= !acc_we;
            RAM_WR   <= acc_we;
            RAM_ADDR <= acc_addr;
            RAM_IN   <= acc_wdata;
        end else begin
            RAM_RD   <= 1'b0;
            RAM_WR   <= 1'b0;
        end
    end

    // Stage p1 -> p2 read tags: only the valid bits are reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= accept && !acc_we;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            id_p1 <= acc_id;
        end
        id_p2 <= id_p1;
    end

    assign RVALID0 = vld_p2 && !id_p2;
    assign RVALID1 = vld_p2 && id_p2;
    assign RDATA0  = RAM_OUT;
    assign RDATA1  = RAM_OUT;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// traffic scored against a transaction-level memory/response model.
module tb_ram_arbiter;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int MB = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ0, REQ1, WE0, WE1;
    logic [AW-1:0] ADDR0, ADDR1;
    logic [DW-1:0] WDATA0, WDATA1;
    logic          GNT0, GNT1, RVALID0, RVALID1;
    logic [DW-1:0] RDATA0, RDATA1;
    logic          RAM_RD, RAM_WR;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_IN;
    logic [DW-1:0] RAM_OUT;

    ram_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
        .RDATA0(RDATA0), .RDATA1(RDATA1),
        .RAM_RD(RAM_RD), .RAM_WR(RAM_WR), .RAM_ADDR(RAM_ADDR), .RAM_IN(RAM_IN),
        .RAM_OUT(RAM_OUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] init_val(input logic [9:0] a);
        return (16'(a) * 16'd40503) ^ 16'h5A5A;
    endfunction

    // Behavioural single-port synchronous RAM the arbiter drives.
    logic [DW-1:0] ram_mem [0:1023];
    bit            ram_seen [0:1023];
    logic [DW-1:0] ram_q;
    assign RAM_OUT = ram_q;
    always @(posedge CLK) begin
        if (RAM_WR) begin
            ram_mem[RAM_ADDR]  <= RAM_IN;
            ram_seen[RAM_ADDR] <= 1'b1;
        end
        if (RAM_RD) ram_q <= ram_seen[RAM_ADDR] ? ram_mem[RAM_ADDR] : init_val(RAM_ADDR);
    end

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed { int due; logic [15:0] data; } rd_t;
    rd_t           q0[$];
    rd_t           q1[$];
    rd_t           m_item;
    logic [15:0]   shadow [0:1023];
    int            mc;
    logic          exp_rd, exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_in;
    logic          m_a0, m_a1, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    int            m_id, m_owner, m_blen;
    logic          ev0, ev1;
    int            acc_log[$];
    int            run_cycles, run_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Compare the outputs of the current cycle against the model.
    task automatic model_check();
        ev0 = (q0.size() > 0) && (q0[0].due == mc);
        ev1 = (q1.size() > 0) && (q1[0].due == mc);
        chk("gnt_excl", 32'(GNT0 && GNT1), 32'(0));
        chk("ram_rd", 32'(RAM_RD), 32'(exp_rd));
        chk("ram_wr", 32'(RAM_WR), 32'(exp_wr));
        chk("ram_addr", 32'(RAM_ADDR), 32'(exp_addr));
        chk("ram_in", 32'(RAM_IN), 32'(exp_in));
        chk("rvalid0", 32'(RVALID0), 32'(ev0));
        chk("rvalid1", 32'(RVALID1), 32'(ev1));
        if (ev0) begin
            chk("rdata0", 32'(RDATA0), 32'(q0[0].data));
            void'(q0.pop_front());
        end
        if (ev1) begin
            chk("rdata1", 32'(RDATA1), 32'(q1[0].data));
            void'(q1.pop_front());
        end
    endtask

    // Apply the transaction rules for the upcoming clock edge.
    task automatic model_step();
        mc++;
        m_a0 = 1'b0;
        m_a1 = 1'b0;
        if (RST) begin
            q0.delete(); q1.delete();
            exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_in = '0;
            m_owner = -1; m_blen = 0;
        end else begin
            m_a0 = REQ0 && GNT0;
            m_a1 = REQ1 && GNT1;
            if (m_a0 || m_a1) begin
                m_id   = m_a1 ? 1 : 0;
                m_we   = m_a1 ? WE1 : WE0;
                m_addr = m_a1 ? ADDR1 : ADDR0;
                m_wd   = m_a1 ? WDATA1 : WDATA0;
                exp_wr = m_we; exp_rd = !m_we; exp_addr = m_addr; exp_in = m_wd;
                if (m_we) begin
                    shadow[m_addr] = m_wd;
                end else begin
                    m_item.due  = mc + 1;
                    m_item.data = shadow[m_addr];
                    if (m_id == 1) q1.push_back(m_item); else q0.push_back(m_item);
                end
                if (m_owner != m_id) begin
                    m_owner = m_id;
                    m_blen  = 0;
                end
                m_blen++;
                chk("burst_len", 32'(m_blen <= MB), 32'(1));
            end else begin
                exp_rd = 1'b0; exp_wr = 1'b0;
                m_owner = -1; m_blen = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        model_check();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic set0(input int i, input int n, input bit mix, input logic [AW-1:0] b);
        REQ0   = (i < n);
        WE0    = mix && (i % 2 == 0);
        ADDR0  = b + AW'(mix ? i / 2 : i);
        WDATA0 = 16'($urandom);
    endtask

    task automatic set1(input int i, input int n, input bit mix, input logic [AW-1:0] b);
        REQ1   = (i < n);
        WE1    = mix && (i % 2 == 0);
        ADDR1  = b + AW'(mix ? i / 2 : i);
        WDATA1 = 16'($urandom);
    endtask

    task automatic run_seq(input int n0, input int n1, input logic [AW-1:0] b0,
                           input logic [AW-1:0] b1, input bit mix);
        int i0 = 0;
        int i1 = 0;
        run_cycles = 0;
        run_gnt    = 0;
        acc_log.delete();
        set0(i0, n0, mix, b0);
        set1(i1, n1, mix, b1);
        while ((i0 < n0 || i1 < n1) && run_cycles < 200) begin
            if (GNT0 || GNT1) run_gnt++;
            tick();
            run_cycles++;
            if (m_a0) begin acc_log.push_back(0); i0++; set0(i0, n0, mix, b0); end
            if (m_a1) begin acc_log.push_back(1); i1++; set1(i1, n1, mix, b1); end
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        chk("run_timeout", 32'(run_cycles < 200), 32'(1));
    endtask

    initial begin
        RST = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
        for (int i = 0; i < 1024; i++) shadow[i] = init_val(10'(i));
        mc = 0; m_owner = -1; m_blen = 0;
        exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_in = '0;
        @(posedge CLK);
        #1;

        // Reset and idle
        tick();
        RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_gnt", 32'({GNT0, GNT1}), 32'(0));
            chk("idle_rvalid", 32'({RVALID0, RVALID1}), 32'(0));
            chk("idle_ram_ctl", 32'({RAM_RD, RAM_WR}), 32'(0));
            chk("idle_ram_addr", 32'(RAM_ADDR), 32'(0));
        end

        // Write 0xA5A5 to 0x3FF, read it back on the next beat
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 10'h3FF; WDATA0 = 16'hA5A5;
        tick();
        chk("wr_grant", 32'(GNT0), 32'(1));
        tick();
        chk("wr_pulse", 32'(RAM_WR), 32'(1));
        chk("wr_no_rd", 32'(RAM_RD), 32'(0));
        chk("wr_addr", 32'(RAM_ADDR), 32'h3FF);
        chk("wr_data", 32'(RAM_IN), 32'hA5A5);
        WE0 = 1'b0;
        tick();
        chk("wr_pulse_end", 32'(RAM_WR), 32'(0));
        chk("rd_issue", 32'(RAM_RD), 32'(1));
        chk("rd_not_yet", 32'(RVALID0), 32'(0));
        REQ0 = 1'b0;
        tick();
        chk("rd_rvalid0", 32'(RVALID0), 32'(1));
        chk("rd_rdata0", 32'(RDATA0), 32'hA5A5);
        chk("rd_rvalid1", 32'(RVALID1), 32'(0));
        tick();
        chk("rd_rvalid0_once", 32'(RVALID0), 32'(0));
        chk("rd_gnt_off", 32'(GNT0), 32'(0));

        // Both requesters, 8 reads each: 4-beat bursts alternate, 0 first
        do_reset();
        run_seq(8, 8, 10'h100, 10'h200, 1'b0);
        chk("rr_count", 32'(acc_log.size()), 32'(16));
        for (int k = 0; k < 16 && k < acc_log.size(); k++)
            chk($sformatf("rr_order_%0d", k), 32'(acc_log[k]), 32'((k / 4) % 2));
        chk("rr_cycles", 32'(run_cycles), 32'(17));
        repeat (4) tick();

        // Requester 1 alone, 10 mixed accesses
        do_reset();
        run_seq(0, 10, 10'h000, 10'h300, 1'b1);
        chk("solo_accepts", 32'(acc_log.size()), 32'(10));
        chk("solo_granted", 32'(run_gnt), 32'(10));
        chk("solo_cycles", 32'(run_cycles), 32'(13));
        repeat (4) tick();

        // Requester 0 drops after 2 beats while requester 1 waits
        do_reset();
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 10'h040;
        tick();
        chk("drop_gnt0", 32'(GNT0), 32'(1));
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 10'h050;
        tick();
        ADDR0 = 10'h041;
        tick();
        REQ0 = 1'b0;
        tick();
        chk("drop_handoff_gnt1", 32'(GNT1), 32'(1));
        chk("drop_handoff_gnt0", 32'(GNT0), 32'(0));
        tick();
        REQ1 = 1'b0;
        repeat (4) tick();

        // After requester 0 drops into IDLE, requester 1 wins the next tie
        do_reset();
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 10'h060;
        tick();
        tick();
        ADDR0 = 10'h061;
        tick();
        REQ0 = 1'b0;
        tick();
        chk("tie_idle", 32'({GNT0, GNT1}), 32'(0));
        REQ0 = 1'b1; ADDR0 = 10'h062; REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 10'h063;
        tick();
        chk("tie_gnt1", 32'(GNT1), 32'(1));
        chk("tie_gnt0", 32'(GNT0), 32'(0));
        tick();
        REQ1 = 1'b0;
        tick();
        chk("tie_back_to_0", 32'(GNT0), 32'(1));
        tick();
        REQ0 = 1'b0;
        repeat (4) tick();

        // Reset one cycle after a read accept
        do_reset();
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 10'h070;
        tick();
        tick();
        REQ0 = 1'b0;
        RST  = 1'b1;
        tick();
        chk("rst_gnt", 32'({GNT0, GNT1}), 32'(0));
        chk("rst_rvalid", 32'({RVALID0, RVALID1}), 32'(0));
        chk("rst_ram_ctl", 32'({RAM_RD, RAM_WR}), 32'(0));
        chk("rst_ram_addr", 32'(RAM_ADDR), 32'(0));
        chk("rst_ram_in", 32'(RAM_IN), 32'(0));
        RST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_no_rvalid", 32'({RVALID0, RVALID1}), 32'(0));
        end

        // Randomized traffic with one mid-run reset
        for (int c = 0; c < 600; c++) begin
            tick();
            RST = (c == 300);
            if (!REQ0 || m_a0) begin
                REQ0   = ($urandom_range(0, 3) != 0);
                WE0    = 1'($urandom_range(0, 1));
                ADDR0  = 10'h380 + 10'($urandom_range(0, 7));
                WDATA0 = 16'($urandom);
            end
            if (!REQ1 || m_a1) begin
                REQ1   = ($urandom_range(0, 3) != 0);
                WE1    = 1'($urandom_range(0, 1));
                ADDR1  = 10'h380 + 10'($urandom_range(0, 7));
                WDATA1 = 16'($urandom);
            end
        end
        RST = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
        repeat (5) tick();
        chk("drain_empty", 32'(q0.size() + q1.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
